// File: rtl/ula_seq_if.sv
// Handshake and operand bus of the sequential ALU ula_seq.
// The master drives the request; the slave (the ALU) answers with status and result.
interface ula_seq_if #(parameter int WIDTH = 4);
  logic               start;
  logic [WIDTH-1:0]   operando1;
  logic [WIDTH-1:0]   operando2;
  logic [3:0]         opcode;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               div_zero;

  modport master (output start, operando1, operando2, opcode,
                  input  busy, done, result, div_zero);
  modport slave  (input  start, operando1, operando2, opcode,
                  output busy, done, result, div_zero);
endinterface

// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle logic/add/sub, WIDTH-cycle shift-add multiply.
// Define ULA_SEQ_DIV_EN to build the WIDTH-cycle restoring divider; otherwise DIV yields 0.
module ula_seq #(
  parameter int WIDTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  ula_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   opb_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] work_q;
  logic [CW-1:0]      count_q;
  logic               dz_q;
  logic [2*WIDTH-1:0] result_q;
  logic               done_q;
  logic               div_zero_q;

  logic [2*WIDTH-1:0] ext1, ext2, single_res;
  logic               single_dz, go_calc;

  assign bus.busy     = (state_q == CALC);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.div_zero = div_zero_q;

  assign ext1 = {{WIDTH{1'b0}}, bus.operando1};
  assign ext2 = {{WIDTH{1'b0}}, bus.operando2};

  // Result of every operation finished at acceptance, and whether CALC is needed.
  always_comb begin
    single_res = '0;
    single_dz  = 1'b0;
    go_calc    = 1'b0;
    case (bus.opcode)
      4'd0: single_res = ext1 + ext2;
      4'd1: single_res = ext1 - ext2;
      4'd2: go_calc    = 1'b1;
`ifdef ULA_SEQ_DIV_EN
      4'd3: begin
        if (bus.operando2 == '0) begin
          single_res = {bus.operando1, {WIDTH{1'b1}}};
          single_dz  = 1'b1;
        end else begin
          go_calc = 1'b1;
        end
      end
`endif
      4'd4: single_res = ext1 & ext2;
      4'd5: single_res = ext1 | ext2;
      4'd6: single_res = ext1 ^ ext2;
      4'd7: single_res = {{WIDTH{1'b0}}, ~bus.operando1};
      default: single_res = '0;
    endcase
  end

`ifdef ULA_SEQ_DIV_EN
  // One restoring step: work_q holds {partial remainder, dividend/quotient bits}.
  logic [WIDTH:0]     trial, diff;
  logic [2*WIDTH-1:0] div_step;
  always_comb begin
    trial = work_q[2*WIDTH-1:WIDTH-1];
    diff  = trial - {1'b0, opb_q};
    if (trial >= {1'b0, opb_q})
      div_step = {diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
    else
      div_step = {trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = go_calc ? CALC : DONE;
      CALC:    if (count_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      opb_q      <= '0;
      mcand_q    <= '0;
      work_q     <= '0;
      count_q    <= '0;
      dz_q       <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q       <= bus.opcode;
            opb_q      <= bus.operando2;
            mcand_q    <= ext1;
            count_q    <= CW'(WIDTH - 1);
            dz_q       <= single_dz;
            div_zero_q <= 1'b0;
            // Multiply accumulates from zero; divide starts from the dividend.
            if (go_calc) work_q <= (bus.opcode == 4'd2) ? '0 : ext1;
            else         work_q <= single_res;
          end
        end
        CALC: begin
          count_q <= count_q - CW'(1);
          if (op_q == 4'd2) begin
            if (opb_q[0]) work_q <= work_q + mcand_q;
            mcand_q <= mcand_q << 1;
            opb_q   <= opb_q >> 1;
          end
`ifdef ULA_SEQ_DIV_EN
          else begin
            work_q <= div_step;
          end
`endif
        end
        DONE: begin
          result_q   <= work_q;
          done_q     <= 1'b1;
          div_zero_q <= dz_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 operando1  input  WIDTH  first operand, unsigned.
REQ-006 operando2  input  WIDTH  second operand, unsigned.
REQ-007 opcode  input  4  operation: 0 ADD, 1 SUB, 2 MULT, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT; 8-15 undefined.
REQ-008 busy  output  1  high in CALC state.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 result  output  2*WIDTH  registered result; holds until next done.
REQ-011 div_zero  output  1  high with done when DIV had operando2 = 0; cleared at next accepted start.

Function
REQ-012 FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-013 IDLE with start=1: operands and opcode registered; MULT/DIV -> CALC; all other opcodes -> DONE with result computed.
REQ-014 Single-cycle ops: start sampled at edge N -> done=1 and result valid in cycle after edge N+1.
REQ-015 MULT: shift-add, exactly WIDTH cycles in CALC; done in cycle after edge N+WIDTH+1.
REQ-016 DIV: restoring division, exactly WIDTH cycles in CALC; same latency as MULT.
REQ-017 DONE lasts one cycle, asserts done, returns to IDLE; next start accepted in the cycle after DONE.
REQ-018 start while busy or in DONE is ignored; no queueing.
REQ-019 Operands changing after acceptance do not affect the in-flight operation.
REQ-020 ADD: zero-extended sum, carry in bit WIDTH.
REQ-021 SUB: (operando1 - operando2) mod 2^(2*WIDTH).
REQ-022 MULT: full 2*WIDTH-bit unsigned product.
REQ-023 DIV: quotient in result[WIDTH-1:0], remainder in result[2*WIDTH-1:WIDTH].
REQ-024 DIV by zero: detected at acceptance; skips CALC (single-cycle latency); quotient all ones, remainder = operando1, div_zero=1.
REQ-025 AND/OR/XOR/NOT: WIDTH-bit bitwise result, upper WIDTH bits zero; NOT uses operando1 only.
REQ-026 Undefined opcodes: single-cycle, result 0, div_zero 0.

Reset
REQ-027 Reset forces IDLE, busy=0, done=0, result=0, div_zero=0, internal datapath registers 0.
REQ-028 Reset during CALC aborts the operation; no done pulse follows reset release.
REQ-029 First start is accepted on the first rising edge with reset low.

Configuration
REQ-030 Macro ULA_SEQ_DIV_EN defined: DIV implemented per REQ-016, REQ-023, REQ-024.
REQ-031 Macro ULA_SEQ_DIV_EN undefined: no divider hardware; DIV single-cycle, result 0, div_zero 0.

Verification (WIDTH=4)
REQ-032 ADD 9,8 -> done one cycle after start, result 0x11.
REQ-033 SUB 3,5 -> result 0xFE, single-cycle.
REQ-034 MULT 15,15 -> busy 4 cycles, done at N+5, result 0xE1; start pulses during busy ignored.
REQ-035 DIV 13,4 (ULA_SEQ_DIV_EN) -> result 0x13, div_zero 0; DIV 7,0 -> result 0x7F, div_zero 1, single-cycle.
REQ-036 Reset asserted mid-DIV 2 cycles after start -> busy 0, result 0 immediately; no done after release.
REQ-037 Opcode 12 with any operands -> result 0x00 single-cycle; NOT 0x5 -> 0x0A.
